// File: rtl/param_signed_multiplier_if.sv
// Serial operand, handshake and product-output signals of param_signed_multiplier.
// master drives operands and strobes; slave is the multiplier.
interface param_signed_multiplier_if;
  logic x_in;
  logic sx;
  logic fx;
  logic y_in;
  logic sy;
  logic fy;
  logic tc_mode;
  logic mul;
  logic busy;
  logic done;
  logic sz;
  logic z_out;
  logic fz;

  modport master (
    output x_in, sx, y_in, sy, tc_mode, mul, sz,
    input  fx, fy, busy, done, z_out, fz
  );

  modport slave (
    input  x_in, sx, y_in, sy, tc_mode, mul, sz,
    output fx, fy, busy, done, z_out, fz
  );
endinterface

// File: rtl/param_signed_multiplier.sv
// Serial-I/O shift-add multiplier, WIDTH-bit operands, signed or unsigned per product.
// Optional MULT_TEST_PORTS_EN exposes the operand shifters and the loaded product.
module param_signed_multiplier #(
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  param_signed_multiplier_if.slave bus
`ifdef MULT_TEST_PORTS_EN
  ,
  output logic [WIDTH-1:0]       x_test,
  output logic [WIDTH-1:0]       y_test,
  output logic [2*WIDTH-1:0]     z_test
`endif
);
  localparam int CNT_W = $clog2(2*WIDTH+1);
  localparam int PW    = 2*WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, MULT, SIGN, DONE} state_e;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic tc);
    return (tc && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, y_q, a_q, b_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]   xcnt_q, ycnt_q, bit_q, ocnt_q;
  logic [PW-1:0]      acc_q, out_q;
  logic               tc_q, sign_q, done_q;
  logic               fx, fy, fz, accept;
  logic [WIDTH:0]     sum;

  assign fx     = (xcnt_q == CNT_W'(WIDTH));
  assign fy     = (ycnt_q == CNT_W'(WIDTH));
  assign fz     = (ocnt_q == '0);
  assign accept = bus.mul && fx && fy && (state_q == IDLE || state_q == DONE);

  assign bus.fx    = fx;
  assign bus.fy    = fy;
  assign bus.fz    = fz;
  assign bus.busy  = (state_q == LOAD) || (state_q == MULT) || (state_q == SIGN);
  assign bus.done  = done_q;
  assign bus.z_out = !fz && out_q[PW-1];

  // Input shifters: a strobe on a full register starts a fresh operand
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0; xcnt_q <= '0;
      y_q <= '0; ycnt_q <= '0;
    end else if (accept) begin
      xcnt_q <= '0;
      ycnt_q <= '0;
    end else begin
      if (bus.sx) begin
        if (fx) begin
          x_q    <= {{(WIDTH-1){1'b0}}, bus.x_in};
          xcnt_q <= CNT_W'(1);
        end else begin
          x_q    <= {x_q[WIDTH-2:0], bus.x_in};
          xcnt_q <= xcnt_q + 1'b1;
        end
      end
      if (bus.sy) begin
        if (fy) begin
          y_q    <= {{(WIDTH-1){1'b0}}, bus.y_in};
          ycnt_q <= CNT_W'(1);
        end else begin
          y_q    <= {y_q[WIDTH-2:0], bus.y_in};
          ycnt_q <= ycnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = LOAD;
      LOAD:       state_d = MULT;
      MULT:       if (bit_q == CNT_W'(WIDTH-1)) state_d = SIGN;
      SIGN:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Upper half plus carry; the carry lands in the MSB after the right shift
  assign sum = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; tc_q <= 1'b0; sign_q <= 1'b0;
      mcand_q <= '0; mplier_q <= '0; acc_q <= '0; bit_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE) && !accept;
      if (accept) begin
        a_q  <= x_q;
        b_q  <= y_q;
        tc_q <= bus.tc_mode;
      end
      case (state_q)
        LOAD: begin
          mcand_q  <= magnitude(a_q, tc_q);
          mplier_q <= magnitude(b_q, tc_q);
          sign_q   <= tc_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          acc_q    <= '0;
          bit_q    <= '0;
        end
        MULT: begin
          acc_q    <= {sum, acc_q[WIDTH-1:1]};
          mplier_q <= mplier_q >> 1;
          bit_q    <= bit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output shifter: a product load takes priority over any pending strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      ocnt_q <= '0;
    end else if (state_q == SIGN) begin
      out_q  <= apply_sign(acc_q, sign_q);
      ocnt_q <= CNT_W'(PW);
    end else if (bus.sz && !fz) begin
      out_q  <= out_q << 1;
      ocnt_q <= ocnt_q - 1'b1;
    end
  end

`ifdef MULT_TEST_PORTS_EN
  logic [PW-1:0] zt_q;

  always_ff @(posedge clk) begin
    if (rst)                  zt_q <= '0;
    else if (state_q == SIGN) zt_q <= apply_sign(acc_q, sign_q);
  end

  assign x_test = x_q;
  assign y_test = y_q;
  assign z_test = zt_q;
`endif

endmodule

// File: tb/tb_param_signed_multiplier.sv
// Randomised and directed bench for param_signed_multiplier at WIDTH=12.
module tb_param_signed_multiplier;
  localparam int W  = 12;
  localparam int PW = 2*W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  param_signed_multiplier_if bus();

`ifdef MULT_TEST_PORTS_EN
  logic [W-1:0]  x_test, y_test;
  logic [PW-1:0] z_test;
`endif

  param_signed_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULT_TEST_PORTS_EN
    ,
    .x_test (x_test),
    .y_test (y_test),
    .z_test (z_test)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y, input bit tc);
    longint xv, yv, p;
    xv = longint'(x);
    yv = longint'(y);
    if (tc && x[W-1]) xv = xv - (longint'(1) << W);
    if (tc && y[W-1]) yv = yv - (longint'(1) << W);
    p = xv * yv;
    return 64'(p) & ((64'd1 << PW) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W-1; i >= 0; i--) begin
      bus.x_in = x[i]; bus.y_in = y[i];
      bus.sx = 1'b1;   bus.sy = 1'b1;
      tick();
      bus.sx = 1'b0;   bus.sy = 1'b0;
    end
  endtask

  task automatic pulse_mul(input bit tc);
    bus.tc_mode = tc;
    bus.mul = 1'b1;
    tick();
    bus.mul = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic shift_out(input int n, output logic [63:0] p);
    p = '0;
    for (int i = 0; i < n; i++) begin
      p = {p[62:0], bus.z_out};
      bus.sz = 1'b1;
      tick();
      bus.sz = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input bit tc);
    int n;
    logic [63:0] p;
    load_ops(x, y);
    check({tag, "_fx_full"}, 64'(bus.fx), 64'd1);
    pulse_mul(tc);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    check({tag, "_fxfy_clr"}, 64'({bus.fx, bus.fy}), 64'd0);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(W+3));
    shift_out(PW, p);
    check({tag, "_prod"}, p, ref_mul(64'(x), 64'(y), tc));
    check({tag, "_fz"}, 64'(bus.fz), 64'd1);
  endtask

  initial begin
    int n;
    logic [63:0] p;
    logic [W-1:0] rx, ry;
    bit rtc;

    bus.x_in = 0; bus.sx = 0; bus.y_in = 0; bus.sy = 0;
    bus.tc_mode = 0; bus.mul = 0; bus.sz = 0;
    repeat (3) tick();
    check("rst_outs", 64'({bus.fx, bus.fy, bus.busy, bus.done, bus.z_out, bus.fz}), 64'b000001);
    rst = 1'b0;
    tick();

    run_op("signed_small", 12'h003, 12'hFFB, 1'b1);
    run_op("neg_sq", 12'h800, 12'h800, 1'b1);
    run_op("neg_x_one", 12'h800, 12'h001, 1'b1);
    run_op("umax", 12'hFFF, 12'hFFF, 1'b0);
    run_op("smin1", 12'hFFF, 12'hFFF, 1'b1);
    run_op("zero_neg", 12'h000, 12'hFF0, 1'b1);

    // mul with only x full is ignored; 13th strobe restarts x
    for (int i = 0; i < W; i++) begin
      bus.x_in = 1'b1; bus.sx = 1'b1; tick(); bus.sx = 1'b0;
    end
    pulse_mul(1'b1);
    check("mul_no_y_busy", 64'(bus.busy), 64'd0);
    tick();
    check("mul_no_y_busy2", 64'(bus.busy), 64'd0);
    check("mul_no_y_fx", 64'(bus.fx), 64'd1);
    bus.sx = 1'b1; tick(); bus.sx = 1'b0;
    check("restart_fx", 64'(bus.fx), 64'd0);
    for (int i = 0; i < W-1; i++) begin
      bus.sx = 1'b1; tick(); bus.sx = 1'b0;
    end
    check("restart_fx_full", 64'(bus.fx), 64'd1);

    // second operand pair shifted in during MULT, then mul while busy
    load_ops(12'h123, 12'hF9C);
    pulse_mul(1'b1);
    load_ops(12'h055, 12'h0AA);
    pulse_mul(1'b0);
    check("busy_mul_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    check("busy_mul_lat", 64'(n), 64'd2);
    repeat (3) tick();
    check("busy_mul_ignored", 64'({bus.busy, bus.done}), 64'b01);
    shift_out(PW, p);
    check("busy_mul_prod", p, ref_mul(64'h123, 64'hF9C, 1'b1));

    // reset mid-MULT with an unread product pending
    load_ops(12'h005, 12'h006);
    pulse_mul(1'b0);
    wait_done(n);
    check("pre_rst_fz", 64'(bus.fz), 64'd0);
    load_ops(12'h7FF, 12'h801);
    pulse_mul(1'b1);
    repeat (6) tick();
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 64'({bus.busy, bus.done, bus.fz, bus.fx, bus.fy}), 64'b00100);
    rst = 1'b0;
    run_op("after_rst", 12'd7, 12'd9, 1'b0);

    // output overwrite by a newer product
    load_ops(12'hABC, 12'h321);
    pulse_mul(1'b0);
    wait_done(n);
    shift_out(5, p);
    load_ops(12'h9A5, 12'h3C7);
    pulse_mul(1'b1);
    wait_done(n);
    check("ovw_lat", 64'(n), 64'(W+3));
    shift_out(PW-1, p);
    check("ovw_fz_before_last", 64'(bus.fz), 64'd0);
    p = {p[62:0], bus.z_out};
    bus.sz = 1'b1; tick(); bus.sz = 1'b0;
    check("ovw_prod", p, ref_mul(64'h9A5, 64'h3C7, 1'b1));
    check("ovw_fz", 64'(bus.fz), 64'd1);
    bus.sz = 1'b1; tick(); bus.sz = 1'b0;
    check("sz_when_empty", 64'({bus.fz, bus.z_out}), 64'b10);

    for (int k = 0; k < 16; k++) begin
      rx  = W'($urandom_range(0, (1 << W) - 1));
      ry  = W'($urandom_range(0, (1 << W) - 1));
      rtc = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), rx, ry, rtc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
